// File: rtl/umstr_ctrl_pkg.sv
// umstr_ctrl_pkg: shared constants for the UDP master control/status bank.
//   - register byte offsets (word aligned)
//   - reset values for configuration registers
//   - CTRL / STATUS bit positions
//   - byte-strobe merge helper used by every RW register
package umstr_ctrl_pkg;

  localparam logic [31:0] OFF_ID      = 32'h00;
  localparam logic [31:0] OFF_CTRL    = 32'h04;
  localparam logic [31:0] OFF_STATUS  = 32'h08;
  localparam logic [31:0] OFF_MAC_LO  = 32'h0C;
  localparam logic [31:0] OFF_MAC_HI  = 32'h10;
  localparam logic [31:0] OFF_SRC_IP  = 32'h14;
  localparam logic [31:0] OFF_DST_IP  = 32'h18;
  localparam logic [31:0] OFF_PORTS   = 32'h1C;
  localparam logic [31:0] OFF_TX_CNT  = 32'h20;
  localparam logic [31:0] OFF_RX_CNT  = 32'h24;
  localparam logic [31:0] OFF_SCRATCH = 32'h28;

  localparam logic [47:0] RST_MAC      = 48'h02_00_00_00_00_01;
  localparam logic [31:0] RST_SRC_IP   = 32'hC0A8_010A;
  localparam logic [31:0] RST_DST_IP   = 32'hC0A8_0101;
  localparam logic [15:0] RST_SRC_PORT = 16'd1234;
  localparam logic [15:0] RST_DST_PORT = 16'd1234;

  localparam int unsigned CTRL_ENABLE_BIT  = 0;
  localparam int unsigned CTRL_CNT_CLR_BIT = 1;
  localparam int unsigned STAT_LINK_BIT    = 0;
  localparam int unsigned STAT_TX_ERR_BIT  = 1;
  localparam int unsigned STAT_RX_ERR_BIT  = 2;

  // Replace only the bytes whose strobe is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/umstr_sat_counter.sv
// umstr_sat_counter: 32-bit saturating event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear, has priority over inc_i
//   inc_i      : increment by one; holds at all-ones instead of wrapping
//   cnt_o      : current count
module umstr_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/umstr_ctrl_regs.sv
// umstr_ctrl_regs: control/status register bank for the UDP master.
//   clk, rst_n          : clock, asynchronous active-low reset
//   reg_wr_* / reg_rd_* : simple register bus from the AXI-lite bridge;
//                         en held until ack, ack is a one-cycle pulse,
//                         wait outputs tied low
//   link_up             : live link status (STATUS bit0)
//   tx/rx_pkt_done      : packet pulses feeding TX_CNT / RX_CNT
//   tx/rx_err           : error pulses feeding sticky STATUS bits
//   cfg_*               : static configuration straight from the registers
module umstr_ctrl_regs
  import umstr_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned DEC_BITS   = 8,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] reg_wr_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  input  logic [STRB_WIDTH-1:0] reg_wr_strb,
  input  logic                  reg_wr_en,
  output logic                  reg_wr_wait,
  output logic                  reg_wr_ack,
  input  logic [ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic                  reg_rd_en,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  reg_rd_wait,
  output logic                  reg_rd_ack,
  input  logic                  link_up,
  input  logic                  tx_pkt_done,
  input  logic                  rx_pkt_done,
  input  logic                  tx_err,
  input  logic                  rx_err,
  output logic                  cfg_enable,
  output logic [47:0]           cfg_src_mac,
  output logic [31:0]           cfg_src_ip,
  output logic [31:0]           cfg_dst_ip,
  output logic [15:0]           cfg_src_port,
  output logic [15:0]           cfg_dst_port
);

  // Handshake state
  logic        wr_ack_q, wr_busy_q;
  logic        rd_ack_q, rd_busy_q;
  logic [31:0] rd_data_q, rd_data_d;
  logic        wr_fire, rd_fire;

  // Register state
  logic        enable_q,  enable_d;
  logic        tx_err_q,  tx_err_d;
  logic        rx_err_q,  rx_err_d;
  logic [31:0] mac_lo_q,  mac_lo_d;
  logic [15:0] mac_hi_q,  mac_hi_d;
  logic [31:0] src_ip_q,  src_ip_d;
  logic [31:0] dst_ip_q,  dst_ip_d;
  logic [31:0] ports_q,   ports_d;
  logic [31:0] scratch_q, scratch_d;
  logic        cnt_clr;

  logic [31:0] tx_cnt, rx_cnt;

  logic [DEC_BITS-1:0] wr_off, rd_off;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;

  assign wr_off = {reg_wr_addr[DEC_BITS-1:2], 2'b00};
  assign rd_off = {reg_rd_addr[DEC_BITS-1:2], 2'b00};
  assign wdata  = reg_wr_data[31:0];
  assign wstrb  = reg_wr_strb[3:0];

  // The busy flag stays set until en drops, so a request held past its ack
  // is not serviced a second time (the bare en && !ack form would re-ack
  // every other cycle).
  assign wr_fire = reg_wr_en && !wr_ack_q && !wr_busy_q;
  assign rd_fire = reg_rd_en && !rd_ack_q && !rd_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q  <= 1'b0;
      wr_busy_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_busy_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ack_q  <= wr_fire;
      wr_busy_q <= reg_wr_en && (wr_busy_q || wr_fire);
      rd_ack_q  <= rd_fire;
      rd_busy_q <= reg_rd_en && (rd_busy_q || rd_fire);
      if (rd_fire) rd_data_q <= rd_data_d;
    end
  end

  // Read mux samples current register values, so a coincident write to the
  // same register is seen as its pre-write value.
  always_comb begin
    rd_data_d = '0;
    case (rd_off)
      DEC_BITS'(OFF_ID):      rd_data_d = VERSION;
      DEC_BITS'(OFF_CTRL):    rd_data_d[CTRL_ENABLE_BIT] = enable_q;
      DEC_BITS'(OFF_STATUS): begin
        rd_data_d[STAT_LINK_BIT]   = link_up;
        rd_data_d[STAT_TX_ERR_BIT] = tx_err_q;
        rd_data_d[STAT_RX_ERR_BIT] = rx_err_q;
      end
      DEC_BITS'(OFF_MAC_LO):  rd_data_d = mac_lo_q;
      DEC_BITS'(OFF_MAC_HI):  rd_data_d = {16'h0000, mac_hi_q};
      DEC_BITS'(OFF_SRC_IP):  rd_data_d = src_ip_q;
      DEC_BITS'(OFF_DST_IP):  rd_data_d = dst_ip_q;
      DEC_BITS'(OFF_PORTS):   rd_data_d = ports_q;
      DEC_BITS'(OFF_TX_CNT):  rd_data_d = tx_cnt;
      DEC_BITS'(OFF_RX_CNT):  rd_data_d = rx_cnt;
      DEC_BITS'(OFF_SCRATCH): rd_data_d = scratch_q;
      default:                rd_data_d = '0;
    endcase
  end

  always_comb begin
    logic [31:0] tmp;
    logic        w1c_tx, w1c_rx;
    enable_d  = enable_q;
    mac_lo_d  = mac_lo_q;
    mac_hi_d  = mac_hi_q;
    src_ip_d  = src_ip_q;
    dst_ip_d  = dst_ip_q;
    ports_d   = ports_q;
    scratch_d = scratch_q;
    cnt_clr   = 1'b0;
    w1c_tx    = 1'b0;
    w1c_rx    = 1'b0;
    tmp       = '0;
    if (wr_fire) begin
      case (wr_off)
        DEC_BITS'(OFF_CTRL): begin
          if (wstrb[0]) begin
            enable_d = wdata[CTRL_ENABLE_BIT];
            cnt_clr  = wdata[CTRL_CNT_CLR_BIT];
          end
        end
        DEC_BITS'(OFF_STATUS): begin
          w1c_tx = wstrb[0] && wdata[STAT_TX_ERR_BIT];
          w1c_rx = wstrb[0] && wdata[STAT_RX_ERR_BIT];
        end
        DEC_BITS'(OFF_MAC_LO):  mac_lo_d  = strb_merge(mac_lo_q, wdata, wstrb);
        DEC_BITS'(OFF_MAC_HI): begin
          tmp      = strb_merge({16'h0000, mac_hi_q}, wdata, wstrb);
          mac_hi_d = tmp[15:0];
        end
        DEC_BITS'(OFF_SRC_IP):  src_ip_d  = strb_merge(src_ip_q, wdata, wstrb);
        DEC_BITS'(OFF_DST_IP):  dst_ip_d  = strb_merge(dst_ip_q, wdata, wstrb);
        DEC_BITS'(OFF_PORTS):   ports_d   = strb_merge(ports_q, wdata, wstrb);
        DEC_BITS'(OFF_SCRATCH): scratch_d = strb_merge(scratch_q, wdata, wstrb);
        default: ;
      endcase
    end
    // A new error pulse outranks a coincident clear.
    tx_err_d = tx_err || (tx_err_q && !w1c_tx);
    rx_err_d = rx_err || (rx_err_q && !w1c_rx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q  <= 1'b0;
      tx_err_q  <= 1'b0;
      rx_err_q  <= 1'b0;
      mac_lo_q  <= RST_MAC[31:0];
      mac_hi_q  <= RST_MAC[47:32];
      src_ip_q  <= RST_SRC_IP;
      dst_ip_q  <= RST_DST_IP;
      ports_q   <= {RST_SRC_PORT, RST_DST_PORT};
      scratch_q <= '0;
    end else begin
      enable_q  <= enable_d;
      tx_err_q  <= tx_err_d;
      rx_err_q  <= rx_err_d;
      mac_lo_q  <= mac_lo_d;
      mac_hi_q  <= mac_hi_d;
      src_ip_q  <= src_ip_d;
      dst_ip_q  <= dst_ip_d;
      ports_q   <= ports_d;
      scratch_q <= scratch_d;
    end
  end

  umstr_sat_counter u_tx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (tx_pkt_done),
    .cnt_o (tx_cnt)
  );

  umstr_sat_counter u_rx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (rx_pkt_done),
    .cnt_o (rx_cnt)
  );

  assign reg_wr_wait  = 1'b0;
  assign reg_rd_wait  = 1'b0;
  assign reg_wr_ack   = wr_ack_q;
  assign reg_rd_ack   = rd_ack_q;
  assign reg_rd_data  = rd_data_q;

  assign cfg_enable   = enable_q;
  assign cfg_src_mac  = {mac_hi_q, mac_lo_q};
  assign cfg_src_ip   = src_ip_q;
  assign cfg_dst_ip   = dst_ip_q;
  assign cfg_src_port = ports_q[31:16];
  assign cfg_dst_port = ports_q[15:0];

endmodule

// File: tb/tb_umstr_ctrl_regs.sv
module tb_umstr_ctrl_regs;

  logic        clk;
  logic        rst_n;
  logic [31:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en;
  logic        reg_wr_wait;
  logic        reg_wr_ack;
  logic [31:0] reg_rd_addr;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        reg_rd_wait;
  logic        reg_rd_ack;
  logic        link_up;
  logic        tx_pkt_done;
  logic        rx_pkt_done;
  logic        tx_err;
  logic        rx_err;
  logic        cfg_enable;
  logic [47:0] cfg_src_mac;
  logic [31:0] cfg_src_ip;
  logic [31:0] cfg_dst_ip;
  logic [15:0] cfg_src_port;
  logic [15:0] cfg_dst_port;

  int n_cmp = 0;
  int n_err = 0;

  umstr_ctrl_regs #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEC_BITS   (8),
    .VERSION    (32'h0001_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr_strb  (reg_wr_strb),
    .reg_wr_en    (reg_wr_en),
    .reg_wr_wait  (reg_wr_wait),
    .reg_wr_ack   (reg_wr_ack),
    .reg_rd_addr  (reg_rd_addr),
    .reg_rd_en    (reg_rd_en),
    .reg_rd_data  (reg_rd_data),
    .reg_rd_wait  (reg_rd_wait),
    .reg_rd_ack   (reg_rd_ack),
    .link_up      (link_up),
    .tx_pkt_done  (tx_pkt_done),
    .rx_pkt_done  (rx_pkt_done),
    .tx_err       (tx_err),
    .rx_err       (rx_err),
    .cfg_enable   (cfg_enable),
    .cfg_src_mac  (cfg_src_mac),
    .cfg_src_ip   (cfg_src_ip),
    .cfg_dst_ip   (cfg_dst_ip),
    .cfg_src_port (cfg_src_port),
    .cfg_dst_port (cfg_dst_port)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; DUT samples on the rising edge;
  // outputs are checked on the following falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic txp, input logic rxe);
    @(negedge clk);
    reg_wr_addr = a; reg_wr_data = d; reg_wr_strb = s; reg_wr_en = 1'b1;
    tx_pkt_done = txp; rx_err = rxe;
    @(negedge clk);
    chk("wr_ack_rise", {63'd0, reg_wr_ack}, 64'd1);
    reg_wr_en = 1'b0; tx_pkt_done = 1'b0; rx_err = 1'b0;
    @(negedge clk);
    chk("wr_ack_fall", {63'd0, reg_wr_ack}, 64'd0);
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    reg_rd_addr = a; reg_rd_en = 1'b1;
    @(negedge clk);
    chk("rd_ack_rise", {63'd0, reg_rd_ack}, 64'd1);
    chk(tag, {32'd0, reg_rd_data}, {32'd0, exp});
    reg_rd_en = 1'b0;
    @(negedge clk);
    chk("rd_ack_fall", {63'd0, reg_rd_ack}, 64'd0);
  endtask

  task automatic pulse_tx(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tx_pkt_done = 1'b1;
      @(negedge clk); tx_pkt_done = 1'b0;
    end
  endtask

  initial begin
    int acks;
    rst_n = 1'b0;
    reg_wr_addr = '0; reg_wr_data = '0; reg_wr_strb = '0; reg_wr_en = 1'b0;
    reg_rd_addr = '0; reg_rd_en = 1'b0;
    link_up = 1'b0; tx_pkt_done = 1'b0; rx_pkt_done = 1'b0; tx_err = 1'b0; rx_err = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wr_ack",   {63'd0, reg_wr_ack}, 64'd0);
    chk("rst_rd_ack",   {63'd0, reg_rd_ack}, 64'd0);
    chk("rst_rd_data",  {32'd0, reg_rd_data}, 64'd0);
    chk("rst_enable",   {63'd0, cfg_enable}, 64'd0);
    chk("rst_mac",      {16'd0, cfg_src_mac}, 64'h0000_0200_0000_0001);
    chk("rst_src_ip",   {32'd0, cfg_src_ip}, 64'hC0A8_010A);
    chk("rst_dst_ip",   {32'd0, cfg_dst_ip}, 64'hC0A8_0101);
    chk("rst_src_port", {48'd0, cfg_src_port}, 64'd1234);
    chk("rst_dst_port", {48'd0, cfg_dst_port}, 64'd1234);
    chk("wr_wait",      {63'd0, reg_wr_wait}, 64'd0);
    chk("rd_wait",      {63'd0, reg_rd_wait}, 64'd0);
    rst_n = 1'b1;
    link_up = 1'b1;

    bus_read("rd_id",     32'h00, 32'h0001_0000);
    bus_read("rd_mac_lo", 32'h0C, 32'h0000_0001);
    bus_read("rd_mac_hi", 32'h10, 32'h0000_0200);
    bus_read("rd_src_ip", 32'h14, 32'hC0A8_010A);
    bus_read("rd_dst_ip", 32'h18, 32'hC0A8_0101);

    // Partial-strobe write to PORTS: only the dst_port bytes change
    bus_write(32'h1C, 32'h1F90_0035, 4'b0011, 1'b0, 1'b0);
    bus_read("rd_ports", 32'h1C, 32'h04D2_0035);
    chk("cfg_dst_port", {48'd0, cfg_dst_port}, 64'h0035);
    chk("cfg_src_port", {48'd0, cfg_src_port}, 64'h04D2);

    // MAC_HI upper bits are not stored
    bus_write(32'h10, 32'hFFFF_ABCD, 4'b1111, 1'b0, 1'b0);
    bus_read("rd_mac_hi2", 32'h10, 32'h0000_ABCD);
    chk("cfg_mac", {16'd0, cfg_src_mac}, 64'h0000_ABCD_0000_0001);

    // TX counter and clear racing an increment
    pulse_tx(5);
    bus_read("tx_cnt5", 32'h20, 32'd5);
    bus_write(32'h04, 32'h0000_0002, 4'b0001, 1'b1, 1'b0);
    bus_read("tx_cnt_clr", 32'h20, 32'd0);
    bus_read("ctrl_rd0",   32'h04, 32'd0);
    bus_write(32'h04, 32'h0000_0001, 4'b0001, 1'b0, 1'b0);
    chk("cfg_enable1", {63'd0, cfg_enable}, 64'd1);
    bus_read("ctrl_rd1", 32'h04, 32'd1);
    // cnt_clr without strb[0] is ignored, enable unaffected
    pulse_tx(2);
    bus_write(32'h04, 32'h0000_0002, 4'b0010, 1'b0, 1'b0);
    bus_read("tx_cnt_nostrb", 32'h20, 32'd2);
    chk("cfg_enable_kept", {63'd0, cfg_enable}, 64'd1);

    // Saturation
    @(negedge clk);
    force dut.u_tx_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_tx_cnt.cnt_q;
    pulse_tx(3);
    bus_read("tx_cnt_sat", 32'h20, 32'hFFFF_FFFF);
    bus_read("rx_cnt0",    32'h24, 32'd0);

    // Sticky errors
    @(negedge clk); rx_err = 1'b1;
    @(negedge clk); rx_err = 1'b0;
    bus_read("status_rx", 32'h08, 32'h5);
    bus_write(32'h08, 32'h4, 4'b0001, 1'b0, 1'b1);
    bus_read("status_race", 32'h08, 32'h5);
    bus_write(32'h08, 32'h4, 4'b0001, 1'b0, 1'b0);
    bus_read("status_w1c", 32'h08, 32'h1);
    @(negedge clk); tx_err = 1'b1;
    @(negedge clk); tx_err = 1'b0;
    bus_write(32'h08, 32'h2, 4'b0000, 1'b0, 1'b0);
    bus_read("status_w1c_nostrb", 32'h08, 32'h3);
    bus_write(32'h08, 32'h2, 4'b0001, 1'b0, 1'b0);
    bus_read("status_w1c_tx", 32'h08, 32'h1);

    // Held write request acks once
    @(negedge clk);
    reg_wr_addr = 32'h28; reg_wr_data = 32'hA5A5_5A5A; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (reg_wr_ack) acks++;
    end
    reg_wr_en = 1'b0;
    @(negedge clk);
    if (reg_wr_ack) acks++;
    chk("held_wr_acks", 64'(acks), 64'd1);
    bus_read("scratch", 32'h28, 32'hA5A5_5A5A);
    bus_read("scratch_alias", 32'h128, 32'hA5A5_5A5A);

    // Coincident read and write of the same register returns the old value
    @(negedge clk);
    reg_wr_addr = 32'h28; reg_wr_data = 32'h1234_5678; reg_wr_strb = 4'hF; reg_wr_en = 1'b1;
    reg_rd_addr = 32'h28; reg_rd_en = 1'b1;
    @(negedge clk);
    chk("rw_wr_ack", {63'd0, reg_wr_ack}, 64'd1);
    chk("rw_rd_ack", {63'd0, reg_rd_ack}, 64'd1);
    chk("rw_rd_old", {32'd0, reg_rd_data}, 64'hA5A5_5A5A);
    reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    bus_read("rw_new", 32'h28, 32'h1234_5678);

    // Unmapped offset
    bus_write(32'h3C, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
    chk("unmapped_src_ip", {32'd0, cfg_src_ip}, 64'hC0A8_010A);
    chk("unmapped_ports",  {32'd0, cfg_src_port, cfg_dst_port}, 64'h04D2_0035);
    bus_read("unmapped_rd", 32'h3C, 32'd0);
    bus_read("scratch_kept", 32'h28, 32'h1234_5678);

    // Reset in the middle of an acknowledged request
    @(negedge clk);
    reg_wr_addr = 32'h04; reg_wr_data = 32'h1; reg_wr_strb = 4'h1; reg_wr_en = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_ack_up", {63'd0, reg_wr_ack}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack",    {63'd0, reg_wr_ack}, 64'd0);
    chk("mid_rst_enable", {63'd0, cfg_enable}, 64'd0);
    chk("mid_rst_mac",    {16'd0, cfg_src_mac}, 64'h0000_0200_0000_0001);
    reg_wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read("post_rst_scratch", 32'h28, 32'd0);
    bus_read("post_rst_tx_cnt",  32'h20, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
